// File: rtl/uart_dl_pkg.sv
// Shared constants, FSM state encoding and the CRC-16/MODBUS byte update
// used by the serial download packet engine.
package uart_dl_pkg;
  localparam int FRAME_LEN = 35;
  localparam int SEQ_OFS   = 0;
  localparam int PAY_OFS   = 1;
  localparam int PAY_LEN   = 32;
  localparam int CRC_OFS   = 33;
  localparam int WORDS     = 8;

  localparam logic [7:0]  ACK_CODE   = 8'h06;
  localparam logic [7:0]  NAK_CODE   = 8'h15;
  localparam logic [15:0] CRC_INIT   = 16'hFFFF;
  localparam logic [15:0] CRC_POLY_R = 16'hA001;  // 0x8005 bit-reversed

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_CHECK,
    ST_WRITE,
    ST_RESP
  } state_e;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                             input logic [7:0]  b);
    logic [15:0] c;
    c = crc_in ^ {8'h00, b};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ CRC_POLY_R) : (c >> 1);
    return c;
  endfunction
endpackage

// File: rtl/uart_dl_pkt_if.sv
// Byte-stream, response and instruction-memory write handshakes of the
// download packet engine, bundled so the engine sees them as one port.
interface uart_dl_pkt_if;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;

  modport slave (
    input  rx_data_i, rx_valid_i, tx_ready_i, mem_gnt_i,
    output tx_data_o, tx_valid_o, mem_req_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output rx_data_i, rx_valid_i, tx_ready_i, mem_gnt_i,
    input  tx_data_o, tx_valid_o, mem_req_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/crc16_modbus.sv
// Single-cycle CRC-16/MODBUS update of a running CRC by one byte.
module crc16_modbus
  import uart_dl_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);
  assign crc_o = crc16_byte(crc_i, data_i);
endmodule

// File: rtl/uart_dl_pkt.sv
// Serial download packet engine: frames 35-byte packets from the UART byte
// stream, validates seq/CRC, writes the payload to imem and answers ACK/NAK.
module uart_dl_pkt
  import uart_dl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 20000,
  parameter logic [7:0]  ACK_BYTE    = ACK_CODE,
  parameter logic [7:0]  NAK_BYTE    = NAK_CODE
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  uart_dl_pkt_if.slave  bus,
  output logic          busy_o,
  output logic [15:0]   pkt_cnt_o,
  output logic          err_o
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_e                 state_q, state_d;
  logic [5:0]             idx_q;
  logic [7:0]             seq_q, exp_seq_q;
  logic [15:0]            crc_q, crc_in, crc_nxt;
  logic [TW-1:0]          tmo_q;
  logic [2:0]             widx_q;
  logic [WORDS-1:0][31:0] buf_q;
  logic [4:0]             pl_idx;
  logic                   tx_valid_q, mem_req_q, busy_q, err_q;
  logic [7:0]             tx_data_q;
  logic [31:0]            mem_addr_q, mem_wdata_q;
  logic [15:0]            pkt_cnt_q;

  logic last_byte, tmo_exp, crc_ok, seq_new, seq_dup, go_write;
  logic wr_fire, last_word, tx_fire, overrun;

  // Running CRC also covers the two trailing CRC bytes, so a clean frame leaves a zero residue.
  assign crc_in = (state_q == ST_IDLE) ? CRC_INIT : crc_q;
  crc16_modbus u_crc (.crc_i(crc_in), .data_i(bus.rx_data_i), .crc_o(crc_nxt));

  assign pl_idx    = 5'(idx_q - 6'd1);
  assign last_byte = (idx_q == 6'(FRAME_LEN - 1));
  assign tmo_exp   = (tmo_q == TW'(TIMEOUT_CYC - 1));
  assign crc_ok    = (crc_q == 16'h0000);
  assign seq_new   = (seq_q == exp_seq_q);
  assign seq_dup   = (seq_q == 8'(exp_seq_q - 8'd1));
  assign go_write  = crc_ok && seq_new;
  assign wr_fire   = mem_req_q && bus.mem_gnt_i;
  assign last_word = (widx_q == 3'(WORDS - 1));
  assign tx_fire   = tx_valid_q && bus.tx_ready_i;
  assign overrun   = bus.rx_valid_i &&
                     (state_q inside {ST_CHECK, ST_WRITE, ST_RESP});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.rx_valid_i) state_d = ST_RECV;
      ST_RECV: begin
        if (bus.rx_valid_i && last_byte) state_d = ST_CHECK;
        else if (!bus.rx_valid_i && tmo_exp) state_d = ST_IDLE;
      end
      ST_CHECK: state_d = go_write ? ST_WRITE : ST_RESP;
      ST_WRITE: if (wr_fire && last_word) state_d = ST_RESP;
      ST_RESP:  if (tx_fire) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (!en_i) state_d = ST_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q       <= '0;
      seq_q       <= '0;
      exp_seq_q   <= '0;
      crc_q       <= CRC_INIT;
      tmo_q       <= '0;
      widx_q      <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      pkt_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      busy_q <= en_i;
      if (!en_i) begin
        idx_q      <= '0;
        exp_seq_q  <= '0;
        tmo_q      <= '0;
        widx_q     <= '0;
        tx_valid_q <= 1'b0;
        tx_data_q  <= '0;
        pkt_cnt_q  <= '0;
        err_q      <= 1'b0;
        // A request already on the bus must see its grant before it is dropped.
        if (!mem_req_q || bus.mem_gnt_i) begin
          mem_req_q   <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
        end
      end else begin
        if (wr_fire) mem_req_q <= 1'b0;
        case (state_q)
          ST_IDLE: if (bus.rx_valid_i) begin
            seq_q <= bus.rx_data_i;
            idx_q <= 6'd1;
            crc_q <= crc_nxt;
            tmo_q <= '0;
          end
          ST_RECV: begin
            if (bus.rx_valid_i) begin
              idx_q <= idx_q + 6'd1;
              crc_q <= crc_nxt;
              tmo_q <= '0;
            end else if (tmo_exp) begin
              err_q <= 1'b1;
            end else begin
              tmo_q <= tmo_q + TW'(1);
            end
          end
          ST_CHECK: begin
            if (go_write) begin
              mem_req_q   <= 1'b1;
              mem_addr_q  <= BASE_ADDR + {19'd0, seq_q, 5'd0};
              mem_wdata_q <= buf_q[0];
              widx_q      <= '0;
            end else begin
              tx_valid_q <= 1'b1;
              tx_data_q  <= (crc_ok && seq_dup) ? ACK_BYTE : NAK_BYTE;
              if (!(crc_ok && seq_dup)) err_q <= 1'b1;
            end
          end
          ST_WRITE: if (wr_fire) begin
            if (last_word) begin
              exp_seq_q  <= exp_seq_q + 8'd1;
              if (pkt_cnt_q != 16'hFFFF) pkt_cnt_q <= pkt_cnt_q + 16'd1;
              tx_valid_q <= 1'b1;
              tx_data_q  <= ACK_BYTE;
            end else begin
              mem_req_q   <= 1'b1;
              widx_q      <= widx_q + 3'd1;
              mem_addr_q  <= mem_addr_q + 32'd4;
              mem_wdata_q <= buf_q[widx_q + 3'd1];
            end
          end
          ST_RESP: if (tx_fire) tx_valid_q <= 1'b0;
          default: ;
        endcase
        if (overrun) err_q <= 1'b1;
      end
    end
  end

  // Payload store needs no reset: every word is rewritten before it can be sent.
  always_ff @(posedge clk_i) begin
    if (en_i && state_q == ST_RECV && bus.rx_valid_i && idx_q < 6'(CRC_OFS))
      buf_q[pl_idx[4:2]][{pl_idx[1:0], 3'b000} +: 8] <= bus.rx_data_i;
  end

  assign bus.tx_valid_o  = tx_valid_q;
  assign bus.tx_data_o   = tx_data_q;
  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign busy_o          = busy_q;
  assign pkt_cnt_o       = pkt_cnt_q;
  assign err_o           = err_q;
endmodule

// File: tb/tb_uart_dl_pkt.sv
// Frame-level bench for uart_dl_pkt: table of packets plus hand sequences for
// disable-mid-write and inter-byte timeout, checked through write/response queues.
module tb_uart_dl_pkt;
  localparam logic [31:0] BASE = 32'h0010_0000;
  localparam int          TMO  = 20000;

  typedef struct {
    logic [7:0]  seq;
    int          pat;      // 0: 01 02 03 00.., 1: random
    bit          bad_crc;
    int          gnt_dly;
    bit          wr;
    logic [7:0]  resp;
    logic [15:0] e_cnt;
    bit          e_err;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk, rst_n, en, busy, err;
  logic [15:0] pkt_cnt;
  uart_dl_pkt_if bus();

  uart_dl_pkt #(.BASE_ADDR(BASE), .TIMEOUT_CYC(TMO), .ACK_BYTE(8'h06), .NAK_BYTE(8'h15)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .bus(bus),
    .busy_o(busy), .pkt_cnt_o(pkt_cnt), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         gnt_dly = 0;
  logic [7:0] frm [35];
  logic [7:0] pay [32];
  wr_t        wq [$];
  logic [7:0] rq [$];
  vec_t       vt [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Bit-serial reference, independent of the byte-wise form in the design.
  function automatic logic [15:0] crc_ref(input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ frm[i][b];
        c  = {1'b0, c[15:1]};
        if (fb) c = c ^ 16'hA001;
      end
    return c;
  endfunction

  task automatic build(input logic [7:0] seq, input int pat, input bit bad);
    logic [15:0] c;
    for (int i = 0; i < 32; i++)
      pay[i] = (pat == 0) ? ((i < 3) ? 8'(i + 1) : 8'h00) : 8'($urandom);
    frm[0] = seq;
    for (int i = 0; i < 32; i++) frm[1 + i] = pay[i];
    c = crc_ref(33);
    frm[33] = c[7:0];
    frm[34] = bad ? ~c[15:8] : c[15:8];
  endtask

  task automatic push_writes(input logic [7:0] seq, input int n);
    wr_t e;
    for (int w = 0; w < n; w++) begin
      e.a = BASE + 32'(seq) * 32'd32 + 32'(w * 4);
      e.d = {pay[4*w+3], pay[4*w+2], pay[4*w+1], pay[4*w]};
      wq.push_back(e);
    end
  endtask

  task automatic send_frame(input int n);
    for (int i = 0; i < n; i++) begin
      bus.rx_valid_i = 1'b1;
      bus.rx_data_i  = frm[i];
      @(negedge clk);
      bus.rx_valid_i = 1'b0;
    end
  endtask

  task automatic drain(input string nm);
    int i;
    i = 0;
    while ((rq.size() != 0 || wq.size() != 0 || bus.tx_valid_o || bus.mem_req_o) && i < 600) begin
      @(negedge clk);
      i++;
    end
    chk({nm, "_drain"}, 32'(rq.size() + wq.size()), 32'd0);
  endtask

  // Memory slave: grants after gnt_dly waiting cycles, checks stability and order.
  initial begin : mem_side
    int          held;
    logic [31:0] a0, d0;
    wr_t         e;
    held = 0; a0 = '0; d0 = '0;
    bus.mem_gnt_i = 1'b0;
    forever begin
      @(negedge clk);
      bus.mem_gnt_i = 1'b0;
      if (bus.mem_req_o) begin
        if (held == 0) begin
          a0 = bus.mem_addr_o;
          d0 = bus.mem_wdata_o;
        end else begin
          chk("mem_stable", bus.mem_addr_o ^ a0 | bus.mem_wdata_o ^ d0, 32'd0);
        end
        if (held >= gnt_dly) begin
          bus.mem_gnt_i = 1'b1;
          held = 0;
          if (wq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL mem_unexp: got write %h @%h expected none", bus.mem_wdata_o, bus.mem_addr_o);
          end else begin
            e = wq.pop_front();
            chk("mem_addr", bus.mem_addr_o, e.a);
            chk("mem_data", bus.mem_wdata_o, e.d);
          end
        end else held++;
      end else held = 0;
    end
  end

  // Response sink: random ready delay, checks byte, stability and deassertion.
  initial begin : tx_side
    int         held, dly;
    logic [7:0] d0;
    bit         acked;
    held = 0; dly = 0; d0 = '0; acked = 1'b0;
    bus.tx_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      bus.tx_ready_i = 1'b0;
      if (acked) begin
        acked = 1'b0;
        held  = 0;
        chk("tx_drop", 32'(bus.tx_valid_o), 32'd0);
      end else if (bus.tx_valid_o) begin
        if (held == 0) begin
          d0  = bus.tx_data_o;
          dly = $urandom_range(0, 3);
        end else begin
          chk("tx_stable", 32'(bus.tx_data_o), 32'(d0));
        end
        if (held >= dly) begin
          bus.tx_ready_i = 1'b1;
          acked = 1'b1;
          if (rq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL tx_unexp: got %h expected none", bus.tx_data_o);
          end else begin
            chk("tx_resp", 32'(bus.tx_data_o), 32'(rq.pop_front()));
          end
        end else held++;
      end
    end
  end

  initial begin : main
    int i;
    vt[0] = '{seq: 8'd0, pat: 0, bad_crc: 1'b0, gnt_dly: 0, wr: 1'b1, resp: 8'h06, e_cnt: 16'd1, e_err: 1'b0};
    vt[1] = '{seq: 8'd1, pat: 1, bad_crc: 1'b1, gnt_dly: 0, wr: 1'b0, resp: 8'h15, e_cnt: 16'd1, e_err: 1'b1};
    vt[2] = '{seq: 8'd0, pat: 0, bad_crc: 1'b0, gnt_dly: 0, wr: 1'b0, resp: 8'h06, e_cnt: 16'd1, e_err: 1'b1};
    vt[3] = '{seq: 8'd2, pat: 1, bad_crc: 1'b0, gnt_dly: 0, wr: 1'b0, resp: 8'h15, e_cnt: 16'd1, e_err: 1'b1};
    vt[4] = '{seq: 8'd1, pat: 1, bad_crc: 1'b0, gnt_dly: 5, wr: 1'b1, resp: 8'h06, e_cnt: 16'd2, e_err: 1'b1};
    vt[5] = '{seq: 8'd2, pat: 1, bad_crc: 1'b0, gnt_dly: 5, wr: 1'b1, resp: 8'h06, e_cnt: 16'd3, e_err: 1'b1};

    rst_n = 1'b0; en = 1'b0;
    bus.rx_valid_i = 1'b0; bus.rx_data_i = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", 32'(bus.tx_valid_o), 32'd0);
    chk("rst_tx_data",  32'(bus.tx_data_o), 32'd0);
    chk("rst_mem_req",  32'(bus.mem_req_o), 32'd0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
    chk("rst_mem_data", bus.mem_wdata_o, 32'd0);
    chk("rst_busy",     32'(busy), 32'd0);
    chk("rst_pkt_cnt",  32'(pkt_cnt), 32'd0);
    chk("rst_err",      32'(err), 32'd0);

    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;
    #1 chk("busy_lat0", 32'(busy), 32'd0);
    @(negedge clk);
    chk("busy_lat1", 32'(busy), 32'd1);

    for (int r = 0; r < 6; r++) begin
      gnt_dly = vt[r].gnt_dly;
      build(vt[r].seq, vt[r].pat, vt[r].bad_crc);
      if (vt[r].wr) push_writes(vt[r].seq, 8);
      rq.push_back(vt[r].resp);
      send_frame(35);
      drain($sformatf("row%0d", r));
      chk($sformatf("row%0d_cnt", r), 32'(pkt_cnt), 32'(vt[r].e_cnt));
      chk($sformatf("row%0d_err", r), 32'(err), 32'(vt[r].e_err));
    end

    // Disable while word 0 of seq 3 is still waiting for its grant.
    gnt_dly = 5;
    build(8'd3, 1, 1'b0);
    push_writes(8'd3, 1);
    send_frame(35);
    i = 0;
    while (!bus.mem_req_o && i < 10) begin @(negedge clk); i++; end
    chk("dis_req_up", 32'(bus.mem_req_o), 32'd1);
    repeat (2) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("dis_req_held", 32'(bus.mem_req_o), 32'd1);
    chk("dis_busy", 32'(busy), 32'd0);
    i = 0;
    while (bus.mem_req_o && i < 20) begin @(negedge clk); i++; end
    chk("dis_req_done", 32'(bus.mem_req_o), 32'd0);
    repeat (2) @(negedge clk);
    chk("dis_addr",    bus.mem_addr_o, 32'd0);
    chk("dis_data",    bus.mem_wdata_o, 32'd0);
    chk("dis_tx",      32'(bus.tx_valid_o), 32'd0);
    chk("dis_cnt",     32'(pkt_cnt), 32'd0);
    chk("dis_err",     32'(err), 32'd0);
    chk("dis_pending", 32'(wq.size()), 32'd0);

    en = 1'b1;
    repeat (2) @(negedge clk);
    gnt_dly = 0;
    build(8'd0, 0, 1'b0);
    push_writes(8'd0, 8);
    rq.push_back(8'h06);
    send_frame(35);
    drain("reen");
    chk("reen_cnt", 32'(pkt_cnt), 32'd1);
    chk("reen_err", 32'(err), 32'd0);

    // Partial frame then silence: dropped exactly on the TMO-th idle clock.
    build(8'd1, 1, 1'b0);
    send_frame(20);
    repeat (TMO - 1) @(negedge clk);
    chk("tmo_early", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_no_tx", 32'(bus.tx_valid_o), 32'd0);

    build(8'd1, 1, 1'b0);
    push_writes(8'd1, 8);
    rq.push_back(8'h06);
    send_frame(35);
    drain("post_tmo");
    chk("post_tmo_cnt", 32'(pkt_cnt), 32'd2);
    chk("post_tmo_err", 32'(err), 32'd1);

    repeat (5) @(negedge clk);
    chk("final_queues", 32'(rq.size() + wq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
